matrix_result_collector: RTL

- Downstream AXI-Stream sink for the matrix multiplier output stream (output_r_*_0); the stage after the matrix generator and multiplier core.
- Accepts result frames with a programmable TREADY throttle pattern and checks frame length against TLAST.
- Reports, per frame: a modular checksum, the beat-to-beat cycle span and error status. Used in real-time on-chip tests and in benches.

---
 rtl/matrix_result_collector_if.sv | 31 +++
 rtl/matrix_result_collector.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/matrix_result_collector_if.sv
// Result-stream handshake bundle between the matrix multiplier output and its sink.
// Latency: none (wires only).
// Backpressure: the sink drives output_r_TREADY_0; the source holds beats until it is sampled high.
//
// Ports (signals):
//   output_r_TVALID_0  source -> sink  beat valid
//   output_r_TLAST_0   source -> sink  end-of-frame marker
//   output_r_TDATA_0   source -> sink  beat payload
//   output_r_TREADY_0  sink -> source  sink ready
interface matrix_result_collector_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  output_r_TVALID_0;
    logic                  output_r_TLAST_0;
    logic [DATA_WIDTH-1:0] output_r_TDATA_0;
    logic                  output_r_TREADY_0;

    modport master (
        output output_r_TVALID_0,
        output output_r_TLAST_0,
        output output_r_TDATA_0,
        input  output_r_TREADY_0
    );

    modport slave (
        input  output_r_TVALID_0,
        input  output_r_TLAST_0,
        input  output_r_TDATA_0,
        output output_r_TREADY_0
    );
endinterface

// File: rtl/matrix_result_collector.sv
// Sink for matrix result frames: checksums each frame, measures its beat span, flags length/timeout errors.
// Latency: results and frame_done appear the cycle after the closing beat (or the timeout edge).
// Backpressure: TREADY follows a rotating throttle pattern and drops for the single DONE cycle.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   s_axis            result stream (slave side of matrix_result_collector_if)
//   frame_done        one-cycle pulse when a frame closes
//   frame_checksum    sum of the closed frame's beats, mod 2^DATA_WIDTH
//   frame_cycles      first-to-last beat span of the closed frame, inclusive, saturating
//   frame_count       frames closed since reset (wraps)
//   error_count       frames closed with an error (saturates)
//   err_early_last    sticky: TLAST before the final beat position
//   err_missing_last  sticky: final beat position reached without TLAST
//   err_timeout       sticky: frame abandoned after TIMEOUT_CYCLES idle cycles
module matrix_result_collector #(
    parameter int             DATA_WIDTH      = 32,
    parameter int             WORDS_PER_FRAME = 16,
    parameter logic [7:0]     READY_PATTERN   = 8'hFF,
    parameter int             TIMEOUT_CYCLES  = 20000
) (
    input  logic                            clk,
    input  logic                            reset,
    matrix_result_collector_if.slave        s_axis,
    output logic                            frame_done,
    output logic [DATA_WIDTH-1:0]           frame_checksum,
    output logic [31:0]                     frame_cycles,
    output logic [15:0]                     frame_count,
    output logic [15:0]                     error_count,
    output logic                            err_early_last,
    output logic                            err_missing_last,
    output logic                            err_timeout
);
    localparam int IDX_W  = $clog2(WORDS_PER_FRAME);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);
    // Compared against the pre-increment value so DONE follows the TIMEOUT_CYCLES-th idle edge.
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [7:0]            pattern;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] sum;
    logic [31:0]           span;
    logic [IDLE_W-1:0]     idle_cnt;

    logic                  beat;
    logic                  at_last_idx;
    logic                  close_beat;
    logic                  early_last;
    logic                  missing_last;
    logic                  timeout;
    logic                  frame_close;
    logic [DATA_WIDTH-1:0] sum_with_beat;
    logic [31:0]           span_inc;

    // Ready comes only from registers: no path from TVALID.
    assign s_axis.output_r_TREADY_0 = pattern[0] && (state != DONE);
    assign frame_done               = (state == DONE);

    assign beat          = s_axis.output_r_TVALID_0 && s_axis.output_r_TREADY_0;
    // idx is 0 in IDLE and WORDS_PER_FRAME >= 2, so a first beat never counts as the last position.
    assign at_last_idx   = (state == RECV) && (idx == LAST_IDX);
    assign close_beat    = beat && (s_axis.output_r_TLAST_0 || at_last_idx);
    assign early_last    = beat && s_axis.output_r_TLAST_0 && !at_last_idx;
    assign missing_last  = beat && !s_axis.output_r_TLAST_0 && at_last_idx;
    assign timeout       = (state == RECV) && !beat && (idle_cnt == IDLE_LIM);
    assign frame_close   = close_beat || timeout;
    assign sum_with_beat = (state == IDLE) ? s_axis.output_r_TDATA_0
                                           : sum + s_axis.output_r_TDATA_0;
    assign span_inc      = (span == 32'hFFFF_FFFF) ? span : span + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (beat) state_nxt = close_beat ? DONE : RECV;
            RECV:    if (frame_close) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern          <= READY_PATTERN;
            idx              <= '0;
            sum              <= '0;
            span             <= '0;
            idle_cnt         <= '0;
            frame_checksum   <= '0;
            frame_cycles     <= '0;
            frame_count      <= '0;
            error_count      <= '0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
            err_timeout      <= 1'b0;
        end else begin
            // Free-running throttle, independent of handshakes.
            pattern <= {pattern[0], pattern[7:1]};

            case (state)
                IDLE: begin
                    if (beat) begin
                        sum      <= s_axis.output_r_TDATA_0;
                        idx      <= IDX_W'(1);
                        span     <= 32'd1;
                        idle_cnt <= '0;
                    end
                end
                RECV: begin
                    span <= span_inc;
                    if (beat) begin
                        sum      <= sum_with_beat;
                        idx      <= idx + IDX_W'(1);
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                default: begin
                    idx      <= '0;
                    sum      <= '0;
                    span     <= '0;
                    idle_cnt <= '0;
                end
            endcase

            if (frame_close) begin
                frame_checksum <= beat ? sum_with_beat : sum;
                frame_cycles   <= (state == IDLE) ? 32'd1 : span_inc;
                frame_count    <= frame_count + 16'd1;
                if ((early_last || missing_last || timeout) && (error_count != 16'hFFFF)) begin
                    error_count <= error_count + 16'd1;
                end
                if (early_last)   err_early_last   <= 1'b1;
                if (missing_last) err_missing_last <= 1'b1;
                if (timeout)      err_timeout      <= 1'b1;
            end
        end
    end
endmodule
